// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg
// Shared definitions for the multi-cycle control FSM: state encoding,
// RV32I base opcodes, pc_sel / wb_sel encodings and the opcode class
// record produced by opcode_class.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic uses_imm;
    } op_class_t;

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if
// Instruction/data memory handshake between the control FSM and memory.
//   imem_req   : fetch request            (FSM -> memory)
//   imem_ready : fetch data valid         (memory -> FSM)
//   dmem_req   : data access request      (FSM -> memory)
//   dmem_we    : data access is a write   (FSM -> memory)
//   dmem_ready : data access complete     (memory -> FSM)
interface control_fsm_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (output imem_req, dmem_req, dmem_we,
                    input  imem_ready, dmem_ready);
    modport slave  (input  imem_req, dmem_req, dmem_we,
                    output imem_ready, dmem_ready);
endinterface

// File: rtl/control_fsm_opcode_class.sv
// opcode_class
// Purely combinational opcode classifier.
//   opcode : 7-bit instruction opcode
//   cls    : {legal, is_load, is_store, is_branch, is_jal, is_jalr, uses_imm}
module opcode_class
    import control_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R:      cls.legal = 1'b1;
            OP_BRANCH: begin cls.legal = 1'b1; cls.is_branch = 1'b1; end
            OP_LOAD:   begin cls.legal = 1'b1; cls.is_load   = 1'b1; cls.uses_imm = 1'b1; end
            OP_STORE:  begin cls.legal = 1'b1; cls.is_store  = 1'b1; cls.uses_imm = 1'b1; end
            OP_JAL:    begin cls.legal = 1'b1; cls.is_jal    = 1'b1; cls.uses_imm = 1'b1; end
            OP_JALR:   begin cls.legal = 1'b1; cls.is_jalr   = 1'b1; cls.uses_imm = 1'b1; end
            OP_IMM, OP_LUI, OP_AUIPC:
                       begin cls.legal = 1'b1; cls.uses_imm  = 1'b1; end
            default:   cls = '0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory,
// writeback, with an absorbing trap state for illegal opcodes (and for
// memory timeouts when CTRL_TIMEOUT_EN is defined).
//
// Build option: `define CTRL_TIMEOUT_EN adds an 8-bit wait counter in
// FETCH/MEMORY; TIMEOUT_CYCLES consecutive not-ready cycles -> TRAP.
// Without it FETCH/MEMORY wait forever.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   mem           : memory handshake (control_fsm_if.master)
//   opcode        : opcode from decoder, stable until retirement
//   branch_taken  : branch compare result, used in EXECUTE
//   ir_we, pc_we, pc_sel, alu_src_b, wb_sel, reg_we : datapath controls
//   state         : current state encoding
//   trap          : fault flag (high only in TRAP)
//   retired       : count of cycles with pc_we=1 (wraps)
//
// state     | meaning
// FETCH     | request instruction, load IR on imem_ready
// DECODE    | check opcode legality
// EXECUTE   | ALU op; branches resolve and retire here
// MEMORY    | data access; stores retire on dmem_ready
// WRITEBACK | register write and PC update, one cycle
// TRAP      | absorbing fault, all strobes low, left only by rst
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    control_fsm_if.master       mem,
    input  logic [6:0]          opcode,
    input  logic                branch_taken,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                alu_src_b,
    output logic [1:0]          wb_sel,
    output logic                reg_we,
    output logic [2:0]          state,
    output logic                trap,
    output logic [31:0]         retired
);

    state_t      state_q, state_d;
    op_class_t   cls;
    logic [31:0] retired_q;
    logic        timeout_hit;

    opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

`ifdef CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       waiting;

    assign waiting = ((state_q == ST_FETCH)  && !mem.imem_ready) ||
                     ((state_q == ST_MEMORY) && !mem.dmem_ready);
    // Counter value TIMEOUT_CYCLES-1 marks the last permitted wait cycle.
    assign timeout_hit = waiting && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= 8'd0;
        else if (waiting && (state_d == state_q))
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= 8'd0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_FETCH;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_q <= 32'd0;
        else if (pc_we)
            retired_q <= retired_q + 32'd1;
    end

    always_comb begin
        state_d      = state_q;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_src_b    = 1'b0;
        wb_sel       = WB_ALU;
        reg_we       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem.imem_req = 1'b1;
                if (timeout_hit) begin
                    state_d = ST_TRAP;
                end else if (mem.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = cls.legal ? ST_EXECUTE : ST_TRAP;
            end
            ST_EXECUTE: begin
                alu_src_b = cls.uses_imm;
                if (cls.is_load || cls.is_store) begin
                    state_d = ST_MEMORY;
                end else if (cls.is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? PC_TARGET : PC_PLUS4;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = cls.is_store;
                if (timeout_hit) begin
                    state_d = ST_TRAP;
                end else if (mem.dmem_ready) begin
                    if (cls.is_store) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
                if (cls.is_load)
                    wb_sel = WB_MEM;
                else if (cls.is_jal || cls.is_jalr)
                    wb_sel = WB_PC4;
                if (cls.is_jal)
                    pc_sel = PC_TARGET;
                else if (cls.is_jalr)
                    pc_sel = PC_JALR;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    assign state   = state_q;
    assign trap    = (state_q == ST_TRAP);
    assign retired = retired_q;

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, memory-wait cycle limit before trap; range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  instruction opcode from decoder; stable from DECODE until the instruction retires.
REQ-005 branch_taken  input  1  branch compare result from ALU; sampled in EXECUTE.
REQ-006 imem_ready  input  1  instruction memory data valid.
REQ-007 dmem_ready  input  1  data memory access complete.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_we  output  1  instruction register load strobe.
REQ-010 dmem_req / dmem_we  output  1 each  data memory request / write qualifier.
REQ-011 pc_we  output  1  PC update strobe.
REQ-012 pc_sel  output  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
REQ-013 alu_src_b  output  1  0 = rs2, 1 = immediate.
REQ-014 wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4.
REQ-015 reg_we  output  1  register file write strobe.
REQ-016 state  output  3  current state encoding.
REQ-017 trap  output  1  sticky fault flag.
REQ-018 retired  output  32  retired-instruction count.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; all outputs are decoded from the registered state plus opcode.
REQ-020 FETCH: imem_req=1; on imem_ready: ir_we=1 that cycle -> DECODE; otherwise stay.
REQ-021 DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111; illegal -> TRAP, else -> EXECUTE.
REQ-022 EXECUTE: alu_src_b=0 for 0110011/1100011, else 1; load/store -> MEMORY; branch -> FETCH with pc_we=1, pc_sel=1 if branch_taken else 0; all others -> WRITEBACK.
REQ-023 MEMORY: dmem_req=1, dmem_we=1 only for store; on dmem_ready: load -> WRITEBACK; store -> FETCH with pc_we=1, pc_sel=0.
REQ-024 WRITEBACK: reg_we=1 and pc_we=1 for exactly one cycle -> FETCH; wb_sel=1 for load, 2 for JAL/JALR, else 0; pc_sel=1 for JAL, 2 for JALR, else 0.
REQ-025 Branch/store/load/ALU latency: 3/4/5/4 cycles minimum, plus memory wait cycles.
REQ-026 retired SHALL increment by 1 on every cycle with pc_we=1; it wraps 0xFFFFFFFF -> 0.
REQ-027 TRAP is absorbing: trap=1; all strobes and requests 0; exit only via rst.
REQ-028 imem_ready outside FETCH and dmem_ready outside MEMORY SHALL be ignored.
REQ-029 pc_we, reg_we, ir_we and dmem_we SHALL never be asserted together with trap=1.

Reset
REQ-030 rst asserted at any time, including mid-wait, forces state=FETCH, trap=0, retired=0 and the wait counter to 0 immediately, without waiting for a clock edge.
REQ-031 After rst deasserts, the first imem_req is asserted in the same cycle.

Configuration
REQ-032 Macro CTRL_TIMEOUT_EN defined: an 8-bit wait counter runs in FETCH/MEMORY, clears on ready or on a state change, and reaching TIMEOUT_CYCLES without ready -> TRAP.
REQ-033 CTRL_TIMEOUT_EN undefined: no counter is present; FETCH/MEMORY wait indefinitely.

Structure
REQ-034 A shared package SHALL hold the state enum, opcode constants, and pc_sel/wb_sel encodings.
REQ-035 A sub-module opcode_class SHALL be combinational, mapping opcode to {legal, is_load, is_store, is_branch, is_jal, is_jalr, uses_imm}.

Verification
REQ-036 ADD (0110011), imem_ready/dmem_ready tied high -> states 0,1,2,4,0; reg_we=1 and wb_sel=0 in the 4th cycle; retired=1.
REQ-037 Load with dmem_ready delayed 3 cycles -> MEMORY held 4 cycles; then WRITEBACK with wb_sel=1; dmem_we=0 throughout.
REQ-038 BEQ with branch_taken=1 -> pc_we=1 and pc_sel=1 in EXECUTE; reg_we is never asserted.
REQ-039 opcode 0000000 -> TRAP after DECODE; trap stays 1 for 100 cycles; rst pulse returns state to FETCH with trap=0.
REQ-040 CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, imem_ready=0 -> TRAP after 4 FETCH cycles; with the macro undefined -> still in FETCH after 100 cycles.
